// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the fetch path
package cpu_pkg;

  localparam int          XLEN        = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h00000013;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - synchronous FIFO of fetch entries with flush
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  logic          push_ok;

  assign pop_ok  = pop_i & (count_q != '0);
  // A push into a full buffer is only legal when the head leaves in the same cycle
  assign push_ok = push_i & ((count_q != CW'(DEPTH)) | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch initiator for a registered-read instruction memory
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en_ip,
  input  logic        redirect_ip,
  input  logic [31:0] redirect_pc_ip,
  output logic [31:0] pc_op,
  input  logic [31:0] instr_ip,
  output logic        instr_valid_op,
  input  logic        instr_ready_ip,
  output logic [31:0] instr_op,
  output logic [31:0] instr_pc_op
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          pop;
  logic          issue;
  logic [CW-1:0] occ;

  assign pop   = instr_valid_op & instr_ready_ip;
  assign occ   = count + CW'(inflight_q);
  // Slot freed by this cycle's pop may be reused by a new issue
  assign issue = fetch_en_ip & ~redirect_ip & ((occ - CW'(pop)) < CW'(BUF_DEPTH));

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_ip) begin
      pc_d = {redirect_pc_ip[31:2], 2'b00};
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + INSTR_BYTES;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign push_entry = '{pc: inflight_pc_q, instr: instr_ip};

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q & ~redirect_ip),
    .entry_i (push_entry),
    .pop_i   (pop & ~redirect_ip),
    .flush_i (redirect_ip),
    .count_o (count),
    .head_o  (head)
  );

  assign pc_op          = pc_q;
  assign instr_valid_op = (count != '0);
  assign instr_op       = instr_valid_op ? head.instr : NOP_INSTR;
  assign instr_pc_op    = instr_valid_op ? head.pc : '0;

endmodule
